fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end of the RV64 pipelined datapath. Owns the fetch PC and issues word requests to a synchronous instruction memory with 1-cycle read latency. Buffers returned instructions in a small queue that forms the IF/ID boundary, so decode-stage stalls never drop or duplicate fetched words. Accepts branch/jump redirects from EX and discards wrong-path instructions.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0, first fetch address after reset
QDEPTH, 2, instruction queue entries (minimum legal value 2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  XLEN  word-aligned fetch address, valid when imem_req=1
imem_rdata  input  32  instruction word, valid exactly one cycle after an imem_req
stall_i  input  1  decode cannot accept the IF/ID entry this cycle
redirect_valid  input  1  taken branch/jump resolved; flush and refetch
redirect_pc  input  XLEN  redirect target
if_id_valid  output  1  IF/ID entry present
if_id_pc  output  XLEN  PC of the IF/ID entry
if_id_inst  output  32  instruction of the IF/ID entry
debug_pc  output  XLEN  current fetch PC (next address to request)

Behaviour:
- Reset: pc_f=RESET_PC, queue empty, no request in flight; imem_req=0, if_id_valid=0, if_id_pc=0, if_id_inst=0, debug_pc=RESET_PC. Reset asserted mid-operation discards all queue contents and any in-flight response; the next response is ignored.
- State: pc_f, inflight flag plus inflight_pc, circular queue (head/tail pointers, count 0..QDEPTH) of {pc, inst}.
- Dequeue (deq) when if_id_valid=1 and stall_i=0. Outputs are driven from the queue head register, not from imem_rdata (no bypass).
- Request rule: imem_req=1 iff !reset && !redirect_valid && (count + inflight - deq) < QDEPTH. On request: imem_addr=pc_f, inflight<=1, inflight_pc<=pc_f, pc_f<=pc_f+4.
- Response: in the cycle after a request, {inflight_pc, imem_rdata} is enqueued at the next edge unless redirect_valid=1 in that cycle.
- Latency: request in cycle N, data on imem_rdata in N+1, if_id_valid with that entry in N+2. Steady state without stalls: one instruction per cycle.
- Enqueue and dequeue in the same cycle are legal; count is unchanged. Overflow is impossible by the request rule. Any enqueue attempt while count=QDEPTH is a design error, and verification flags it with an assertion.
- Redirect (priority over stall and over normal fetch): at the edge, queue is flushed (count=0), the in-flight response arriving that cycle is discarded, inflight<=0, pc_f<=redirect_pc with bits[1:0] forced to 0, and imem_req=0 that cycle. Next cycle requests redirect_pc, so the first target entry is visible 3 cycles after the redirect cycle.
- stall_i only blocks dequeue; outputs hold stable while stalled.
- When the queue is empty, if_id_valid=0 and if_id_pc/if_id_inst hold their last values.
- Arithmetic: pc_f+4 modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Ordering: entries leave in exactly request order; no loss or duplication across any stall/redirect pattern.

Test Plan:
- Reset release at cycle 0 -> imem_addr=0 at cycle 0; if_id_pc=0,4,8,12 on consecutive cycles starting cycle 2; if_id_inst matches a ROM model.
- Hold stall_i=1 for 3 cycles mid-stream -> if_id_pc/inst hold; imem_req drops once count+inflight reaches 2; after release, the PC sequence resumes with no gap or repeat.
- redirect_valid with redirect_pc=0x100 while an entry is in flight and the queue is full -> wrong-path entries never appear; if_id_valid=0 for 2 cycles; if_id_pc=0x100 at redirect cycle+3, then 0x104.
- Redirect and stall_i in the same cycle, with redirect_pc=0x203 -> redirect wins; fetch resumes at 0x200.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> if_id_pc sequence FFF8, FFFC, 0, 4.
- Assert reset for one cycle mid-stream with an entry in flight -> if_id_valid=0 next cycle; the stale response is not enqueued; the stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads,
// and buffers returned words in a small circular queue that forms the IF/ID boundary.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_inst,
    output logic [XLEN-1:0] debug_pc
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    // Wide enough to hold count + inflight without overflow.
    localparam int unsigned CW = $clog2(QDEPTH + 2) + 1;

    logic [XLEN-1:0] pc_f;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] pc_q   [QDEPTH];
    logic [31:0]     inst_q [QDEPTH];

    logic            deq;
    logic            enq;
    logic [CW-1:0]   occ;
    logic [PW-1:0]   head_n;
    logic [PW-1:0]   tail_n;
    logic [CW-1:0]   count_n;
    logic [XLEN-1:0] pc_f_n;
    logic [XLEN-1:0] nxt_pc;
    logic [31:0]     nxt_inst;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign imem_addr = pc_f;
    assign debug_pc  = pc_f;

    // Request throttle, queue pointer updates and the entry that becomes the next head.
    always_comb begin
        deq      = if_id_valid && !stall_i;
        enq      = inflight && !redirect_valid;
        occ      = count + CW'(inflight) - CW'(deq);
        imem_req = !reset && !redirect_valid && (occ < CW'(QDEPTH));
        head_n   = deq ? ptr_inc(head) : head;
        tail_n   = enq ? ptr_inc(tail) : tail;
        count_n  = count + CW'(enq) - CW'(deq);
        pc_f_n   = imem_req ? pc_f + XLEN'(4) : pc_f;
        nxt_pc   = pc_q[head_n];
        nxt_inst = inst_q[head_n];
        // Queue drains to empty this cycle, so the arriving word becomes the head.
        if ((count - CW'(deq)) == '0) begin
            nxt_pc   = inflight_pc;
            nxt_inst = imem_rdata;
        end
        if (redirect_valid) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
            pc_f_n  = redirect_pc & ~XLEN'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= '0;
        end else begin
            pc_f        <= pc_f_n;
            inflight    <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc_f;
            end
            head        <= head_n;
            tail        <= tail_n;
            count       <= count_n;
            if_id_valid <= (count_n != '0);
            // Outputs hold their last entry while the queue is empty.
            if (count_n != '0) begin
                if_id_pc   <= nxt_pc;
                if_id_inst <= nxt_inst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            pc_q[tail]   <= inflight_pc;
            inst_q[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/reset checks plus a randomized
// run scored against an instruction-stream model (sequential PCs restarted on redirect/reset).
module tb_fetch_unit;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall_i;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [63:0] debug_pc;

    logic        stall2;
    logic        redirect2;
    logic [63:0] redirect_pc2;
    logic        imem_req2;
    logic [63:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        if_id_valid2;
    logic [63:0] if_id_pc2;
    logic [31:0] if_id_inst2;
    logic [63:0] debug_pc2;

    fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .debug_pc(debug_pc)
    );

    fetch_unit #(.XLEN(64), .RESET_PC(WRAP_PC), .QDEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .stall_i(stall2), .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
        .if_id_valid(if_id_valid2), .if_id_pc(if_id_pc2), .if_id_inst(if_id_inst2),
        .debug_pc(debug_pc2)
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        logic [31:0] h;
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Synchronous ROM; garbage on cycles without a request.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? rom(imem_addr)  : 32'($urandom);
        imem_rdata2 <= imem_req2 ? rom(imem_addr2) : 32'($urandom);
    end

    int tests = 0;
    int fails = 0;
    int deliveries = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic rv, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        reset          = r;
        stall_i        = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    // Scoreboard: expected architectural stream, restarted on reset/redirect.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] gen_pc = 64'h0;
    int          bubble = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            gen_pc    = 64'h0;
            bubble    = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_hold_valid", 64'(if_id_valid), 64'd1);
                chk("stall_hold_pc", if_id_pc, prev_pc);
                chk("stall_hold_inst", 64'(if_id_inst), 64'(prev_inst));
            end
            if (if_id_valid && !stall_i) begin
                deliveries++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_id_pc, e.pc);
                    chk("sb_inst", 64'(if_id_inst), 64'(e.inst));
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                gen_pc = redirect_pc & ~64'h3;
                bubble = 0;
            end else if (!if_id_valid) begin
                bubble++;
            end else begin
                bubble = 0;
            end
            chk("bubble_bound", 64'(bubble > 2), 64'd0);
            prev_hold = if_id_valid && stall_i && !redirect_valid;
            prev_pc   = if_id_pc;
            prev_inst = if_id_inst;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: gen_pc, inst: rom(gen_pc)});
            gen_pc = gen_pc + 64'd4;
        end
    end

    // Overflow can only arise from a broken request throttle.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(dut.enq && dut.count == 2)) else begin
                fails++;
                $display("FAIL queue_overflow: enqueue with count=%0d", dut.count);
            end
        end
    end

    logic        r_r;
    logic        r_s;
    logic        r_rv;
    logic [63:0] r_pc;

    initial begin
        reset          = 1'b1;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        stall2         = 1'b0;
        redirect2      = 1'b0;
        redirect_pc2   = 64'h0;

        cyc(1, 0, 0, 64'h0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(if_id_valid), 64'd0);
        chk("rst_pc", if_id_pc, 64'h0);
        chk("rst_inst", 64'(if_id_inst), 64'h0);
        chk("rst_debug_pc", debug_pc, 64'h0);
        chk("rst_debug_pc_wrap", debug_pc2, WRAP_PC);

        // Reset release: cycle 0 requests RESET_PC, first entry visible at cycle 2.
        cyc(0, 0, 0, 64'h0);
        chk("c0_req", 64'(imem_req), 64'd1);
        chk("c0_addr", imem_addr, 64'h0);
        chk("c0_valid", 64'(if_id_valid), 64'd0);
        chk("c0_addr_wrap", imem_addr2, WRAP_PC);
        cyc(0, 0, 0, 64'h0);
        chk("c1_valid", 64'(if_id_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 64'h0);
            chk("start_valid", 64'(if_id_valid), 64'd1);
            chk("start_pc", if_id_pc, 64'(4 * i));
            chk("start_inst", 64'(if_id_inst), 64'(rom(64'(4 * i))));
            chk("wrap_pc", if_id_pc2, WRAP_PC + 64'(4 * i));
        end

        // Three-cycle stall: head holds at 16, requests stop once two words are owned.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 64'h0);
            chk("stall_pc", if_id_pc, 64'd16);
            chk("stall_valid", 64'(if_id_valid), 64'd1);
            if (i > 0) chk("stall_req", 64'(imem_req), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 64'h0);
            chk("resume_pc", if_id_pc, 64'(16 + 4 * i));
        end

        // Redirect with a word in flight.
        cyc(0, 0, 1, 64'h100);
        chk("redir_req", 64'(imem_req), 64'd0);
        cyc(0, 0, 0, 64'h0);
        chk("redir1_valid", 64'(if_id_valid), 64'd0);
        chk("redir1_req", 64'(imem_req), 64'd1);
        chk("redir1_addr", imem_addr, 64'h100);
        cyc(0, 0, 0, 64'h0);
        chk("redir2_valid", 64'(if_id_valid), 64'd0);
        cyc(0, 0, 0, 64'h0);
        chk("redir3_valid", 64'(if_id_valid), 64'd1);
        chk("redir3_pc", if_id_pc, 64'h100);
        cyc(0, 0, 0, 64'h0);
        chk("redir4_pc", if_id_pc, 64'h104);

        // Fill the queue, then redirect and stall together to an unaligned target.
        cyc(0, 1, 0, 64'h0);
        cyc(0, 1, 1, 64'h203);
        chk("rs_req", 64'(imem_req), 64'd0);
        cyc(0, 0, 0, 64'h0);
        chk("rs1_valid", 64'(if_id_valid), 64'd0);
        chk("rs1_addr", imem_addr, 64'h200);
        cyc(0, 0, 0, 64'h0);
        chk("rs2_valid", 64'(if_id_valid), 64'd0);
        cyc(0, 0, 0, 64'h0);
        chk("rs3_pc", if_id_pc, 64'h200);
        cyc(0, 0, 0, 64'h0);
        chk("rs4_pc", if_id_pc, 64'h204);

        // One-cycle reset mid-stream with a request outstanding.
        cyc(0, 0, 0, 64'h0);
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        chk("mrst1_valid", 64'(if_id_valid), 64'd0);
        chk("mrst1_addr", imem_addr, 64'h0);
        cyc(0, 0, 0, 64'h0);
        chk("mrst2_valid", 64'(if_id_valid), 64'd0);
        cyc(0, 0, 0, 64'h0);
        chk("mrst3_pc", if_id_pc, 64'h0);
        chk("mrst3_inst", 64'(if_id_inst), 64'(rom(64'h0)));

        deliveries = 0;
        for (int n = 0; n < 3000; n++) begin
            r_r  = ($urandom_range(0, 199) == 0);
            r_s  = ($urandom_range(0, 3) == 0);
            r_rv = ($urandom_range(0, 19) == 0);
            r_pc = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                               : 64'($urandom_range(0, 65535));
            cyc(r_r, r_s, r_rv, r_pc);
        end
        cyc(0, 0, 0, 64'h0);
        chk("random_throughput", 64'(deliveries > 1500), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
